// File: rtl/supercar_pkg.sv
// Shared definitions for the supercar LED scanner: motion mode codes and FSM states.
package supercar_pkg;

  localparam logic [1:0] MODE_BOUNCE  = 2'b00;
  localparam logic [1:0] MODE_WRAP_UP = 2'b01;
  localparam logic [1:0] MODE_WRAP_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Step-rate prescaler: one tick every div+1 enabled cycles, frozen while en is low.
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap;

  // div is captured at each wrap or clear so a live change only shapes the next period
  always_comb begin
    wrap    = (count_q == div_q);
    tick    = en && !clr && wrap;
    count_d = count_q;
    div_d   = div_q;
    if (clr) begin
      count_d = '0;
      div_d   = div;
    end else if (en) begin
      if (wrap) begin
        count_d = '0;
        div_d   = div;
      end else begin
        count_d = count_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= '0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/supercar_scanner.sv
// Supercar LED scanner: moves a TRAIL-long lit head across N_BIT outputs in bounce or wrap modes,
// stepping on prescaler ticks, with an optional dwell at the bar ends when bouncing.
module supercar_scanner
  import supercar_pkg::*;
#(
  parameter int N_BIT   = 8,
  parameter int TRAIL   = 3,
  parameter int DIV_W   = 16,
  parameter int DWELL_W = 4,
  localparam int PW     = $clog2(N_BIT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_BIT-1:0]   pout,
  output logic [PW-1:0]      pos,
  output logic               dir,
  output logic               edge_hit,
  output logic               busy
);

  localparam logic [PW-1:0] LAST = PW'(N_BIT - 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N_BIT-1:0]   pout_q, pout_d;
  logic               edge_q, edge_d;
  logic               busy_q, busy_d;
  logic               tick, clr, at_end, stepped, wrap_trail;
  logic [PW-1:0]      pos_up, pos_dn;

  // Lit set is the head plus TRAIL-1 indices behind it; wrapped modulo N_BIT or clipped at the ends
  function automatic logic [N_BIT-1:0] trail_mask(input logic [PW-1:0] p, input logic d,
                                                   input logic wrap);
    logic [N_BIT-1:0] m;
    int idx;
    m = '0;
    for (int k = 0; k < TRAIL; k++) begin
      idx = d ? (int'(p) - k) : (int'(p) + k);
      if (wrap) begin
        if (idx < 0) idx = idx + N_BIT;
        else if (idx >= N_BIT) idx = idx - N_BIT;
      end
      if (idx >= 0 && idx < N_BIT) m = m | (N_BIT'(1) << idx);
    end
    return m;
  endfunction

  assign clr = start || stop || (state_q == ST_IDLE);

  scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    stepped    = 1'b0;
    pos_up     = pos_q + PW'(1);
    pos_dn     = pos_q - PW'(1);
    at_end     = dir_q ? (pos_q == LAST) : (pos_q == '0);
    if (stop) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      dir_d   = 1'b1;
      cnt_d   = '0;
    end else if (start) begin
      state_d = ST_RUN;
      pos_d   = '0;
      dir_d   = 1'b1;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_RUN: begin
          case (mode)
            MODE_BOUNCE: begin
              if (!at_end) begin
                pos_d   = dir_q ? pos_up : pos_dn;
                stepped = 1'b1;
              end else if (dwell == '0) begin
                dir_d   = ~dir_q;
                pos_d   = dir_q ? pos_dn : pos_up;
                stepped = 1'b1;
              end else begin
                cnt_d   = dwell;
                state_d = ST_DWELL;
              end
            end
            MODE_WRAP_UP: begin
              dir_d   = 1'b1;
              pos_d   = (pos_q == LAST) ? '0 : pos_up;
              stepped = 1'b1;
            end
            MODE_WRAP_DN: begin
              dir_d   = 1'b0;
              pos_d   = (pos_q == '0) ? LAST : pos_dn;
              stepped = 1'b1;
            end
            default: ;
          endcase
        end
        ST_DWELL: begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (cnt_q == DWELL_W'(1)) begin
            state_d = ST_RUN;
            dir_d   = ~dir_q;
            pos_d   = dir_q ? pos_dn : pos_up;
            stepped = 1'b1;
          end
        end
        default: ;
      endcase
    end
    edge_d     = stepped && ((pos_d == '0) || (pos_d == LAST));
    busy_d     = (state_d != ST_IDLE);
    wrap_trail = (state_d == ST_RUN) && ((mode == MODE_WRAP_UP) || (mode == MODE_WRAP_DN));
    pout_d     = (state_d == ST_IDLE) ? '0 : trail_mask(pos_d, dir_d, wrap_trail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      pout_q  <= '0;
      edge_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      edge_q  <= edge_d;
      busy_q  <= busy_d;
    end
  end

  assign pout     = pout_q;
  assign pos      = pos_q;
  assign dir      = dir_q;
  assign edge_hit = edge_q;
  assign busy     = busy_q;

endmodule
